// File: rtl/descrambler_ctrl.sv
// descrambler_ctrl
//   Sequencing controller for the 58-bit self-synchronizing descrambler in
//   the 100GbE PCS receive path. It sits between block lock/lane deskew and
//   the decoder, and it has four jobs:
//     - gate the descrambler enable
//     - require a flush period after lock or after reconfiguration
//     - change bypass only at safe points
//     - produce the output-valid qualifier that lines up with the
//       descrambler's one-cycle registered output
//   It also counts invalid sync headers (00/11) seen while in service.
//
// Parameters
//   N_FLUSH         valid blocks pushed through before output is valid (1..255)
//   NB_ERR_CNT      width of the saturating sync-header error counter
//   TIMEOUT_CYCLES  flush watchdog limit in clock cycles (optional feature only)
//
// Ports
//   i_clock          clock
//   i_reset          synchronous, active-high reset
//   i_block_lock     block lock from the lock FSM (0 = lock lost)
//   i_valid          a block is on the datapath this cycle
//   i_sync_header    sync header of the current block
//   i_bypass_req     requested bypass configuration (level)
//   i_clr_cnt        clear the error counter (pulse)
//   o_desc_enable    descrambler enable/valid (combinational)
//   o_desc_bypass    descrambler bypass (registered)
//   o_valid          descrambler output block valid (registered)
//   o_state          current FSM state (0 WAIT_LOCK, 1 FLUSH, 2 RUN, 3 RECONF)
//   o_hdr_err_cnt    saturating count of invalid sync headers seen in RUN
//   o_flush_timeout  one-cycle pulse when the flush watchdog fires
//                    (present only with DESC_CTRL_FLUSH_TIMEOUT_EN)
//
// Optional feature
//   Define DESC_CTRL_FLUSH_TIMEOUT_EN to enable the FLUSH watchdog. With the
//   macro undefined, FLUSH waits indefinitely for valid blocks.

module descrambler_ctrl #(
    parameter int unsigned N_FLUSH        = 2,
    parameter int unsigned NB_ERR_CNT     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_block_lock,
    input  logic                  i_valid,
    input  logic [1:0]            i_sync_header,
    input  logic                  i_bypass_req,
    input  logic                  i_clr_cnt,
    output logic                  o_desc_enable,
    output logic                  o_desc_bypass,
    output logic                  o_valid,
    output logic [1:0]            o_state,
    output logic [NB_ERR_CNT-1:0] o_hdr_err_cnt
`ifdef DESC_CTRL_FLUSH_TIMEOUT_EN
   ,output logic                  o_flush_timeout
`endif
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FLUSH     = 2'd1,
        RUN       = 2'd2,
        RECONF    = 2'd3
    } state_t;

    localparam logic [7:0] FLUSH_LAST = 8'(N_FLUSH - 1);

    state_t     state, state_nxt;
    logic [7:0] flush_cnt, flush_cnt_nxt;
    logic       bypass_nxt;
    logic       hdr_bad;

`ifdef DESC_CTRL_FLUSH_TIMEOUT_EN
    // Counts idle cycles up to TIMEOUT_CYCLES-1 only; the firing cycle is the
    // TIMEOUT_CYCLES-th idle one, so the counter never has to hold the limit.
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
    logic            timeout_nxt;
`endif

    assign o_state = state;
    assign hdr_bad = (i_sync_header == 2'b00) || (i_sync_header == 2'b11);

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        bypass_nxt    = o_desc_bypass;
        o_desc_enable = 1'b0;
`ifdef DESC_CTRL_FLUSH_TIMEOUT_EN
        wd_cnt_nxt    = '0;
        timeout_nxt   = 1'b0;
`endif
        case (state)
            WAIT_LOCK: begin
                // Bypass follows the request while idle. The exit decision
                // uses the value already applied to the descrambler.
                bypass_nxt    = i_bypass_req;
                flush_cnt_nxt = '0;
                state_nxt     = o_desc_bypass ? RUN : FLUSH;
            end
            FLUSH: begin
                o_desc_enable = i_valid;
                if (i_valid) begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state_nxt     = RUN;
                        flush_cnt_nxt = '0;
                    end else begin
                        flush_cnt_nxt = flush_cnt + 8'd1;
                    end
                end
`ifdef DESC_CTRL_FLUSH_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    state_nxt   = WAIT_LOCK;
                    timeout_nxt = 1'b1;
                end else begin
                    wd_cnt_nxt = wd_cnt + WD_W'(1);
                end
`endif
            end
            RUN: begin
                // The current block is still processed with the old bypass.
                o_desc_enable = i_valid;
                if (i_bypass_req != o_desc_bypass)
                    state_nxt = RECONF;
            end
            RECONF: begin
                bypass_nxt    = i_bypass_req;
                flush_cnt_nxt = '0;
                state_nxt     = i_bypass_req ? RUN : FLUSH;
            end
            default: state_nxt = WAIT_LOCK;
        endcase

        // Lock loss overrides every other transition.
        if (!i_block_lock) begin
            state_nxt     = WAIT_LOCK;
            flush_cnt_nxt = '0;
`ifdef DESC_CTRL_FLUSH_TIMEOUT_EN
            timeout_nxt   = 1'b0;
`endif
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= WAIT_LOCK;
            flush_cnt     <= '0;
            o_desc_bypass <= 1'b0;
            o_valid       <= 1'b0;
        end else begin
            state         <= state_nxt;
            flush_cnt     <= flush_cnt_nxt;
            o_desc_bypass <= bypass_nxt;
            // Aligns with the descrambler's registered output; a block in the
            // last RUN cycle is still reported when leaving RUN.
            o_valid       <= (state == RUN) && i_valid;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr_cnt)
            o_hdr_err_cnt <= '0;
        else if ((state == RUN) && i_valid && hdr_bad && (o_hdr_err_cnt != '1))
            o_hdr_err_cnt <= o_hdr_err_cnt + NB_ERR_CNT'(1);
    end

`ifdef DESC_CTRL_FLUSH_TIMEOUT_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wd_cnt          <= '0;
            o_flush_timeout <= 1'b0;
        end else begin
            wd_cnt          <= wd_cnt_nxt;
            o_flush_timeout <= timeout_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_descrambler_ctrl.sv
module tb_descrambler_ctrl;

    localparam int unsigned N_FLUSH        = 2;
    localparam int unsigned NB_ERR_CNT     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int          ERR_MAX        = 15;
`ifdef DESC_CTRL_FLUSH_TIMEOUT_EN
    localparam bit          TIMEOUT_EN     = 1'b1;
`else
    localparam bit          TIMEOUT_EN     = 1'b0;
`endif

    logic                  i_clock = 1'b0;
    logic                  i_reset;
    logic                  i_block_lock;
    logic                  i_valid;
    logic [1:0]            i_sync_header;
    logic                  i_bypass_req;
    logic                  i_clr_cnt;
    logic                  o_desc_enable;
    logic                  o_desc_bypass;
    logic                  o_valid;
    logic [1:0]            o_state;
    logic [NB_ERR_CNT-1:0] o_hdr_err_cnt;
    logic                  flush_to;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: state as an integer, plain counters
    int m_state, m_fl, m_err, m_wd;
    bit m_bypass, m_valid, m_to;
    bit en_seen, en_model;

    descrambler_ctrl #(
        .N_FLUSH(N_FLUSH),
        .NB_ERR_CNT(NB_ERR_CNT),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_block_lock(i_block_lock),
        .i_valid(i_valid),
        .i_sync_header(i_sync_header),
        .i_bypass_req(i_bypass_req),
        .i_clr_cnt(i_clr_cnt),
        .o_desc_enable(o_desc_enable),
        .o_desc_bypass(o_desc_bypass),
        .o_valid(o_valid),
        .o_state(o_state),
        .o_hdr_err_cnt(o_hdr_err_cnt)
`ifdef DESC_CTRL_FLUSH_TIMEOUT_EN
       ,.o_flush_timeout(flush_to)
`endif
    );

`ifndef DESC_CTRL_FLUSH_TIMEOUT_EN
    assign flush_to = 1'b0;
`endif

    always #5 i_clock = ~i_clock;

    task automatic model_update(input bit rst, input bit lock, input bit valid,
                                input bit [1:0] hdr, input bit breq, input bit clr);
        int ns;
        bit nb;
        if (rst) begin
            m_state = 0; m_fl = 0; m_err = 0; m_wd = 0;
            m_bypass = 0; m_valid = 0; m_to = 0;
            return;
        end
        ns   = m_state;
        nb   = m_bypass;
        m_to = 0;
        m_valid = (m_state == 2) && valid;
        if (clr)
            m_err = 0;
        else if (m_state == 2 && valid && (hdr == 2'b00 || hdr == 2'b11) && m_err < ERR_MAX)
            m_err = m_err + 1;
        case (m_state)
            0: begin nb = breq; ns = m_bypass ? 2 : 1; m_fl = 0; m_wd = 0; end
            1: begin
                if (valid) begin
                    m_fl = m_fl + 1;
                    m_wd = 0;
                    if (m_fl == N_FLUSH) ns = 2;
                end else begin
                    m_wd = m_wd + 1;
                    if (TIMEOUT_EN && m_wd == TIMEOUT_CYCLES) begin ns = 0; m_to = 1; end
                end
            end
            2: if (breq != m_bypass) ns = 3;
            default: begin nb = breq; ns = breq ? 2 : 1; m_fl = 0; m_wd = 0; end
        endcase
        if (!lock) begin ns = 0; m_fl = 0; m_to = 0; end
        m_state  = ns;
        m_bypass = nb;
    endtask

    // One clock: drive inputs, sample the combinational enable before the
    // edge, advance the model at the edge, leave time at edge+1 for checks.
    task automatic step(input bit rst, input bit lock, input bit valid,
                        input bit [1:0] hdr, input bit breq, input bit clr);
        i_reset = rst; i_block_lock = lock; i_valid = valid;
        i_sync_header = hdr; i_bypass_req = breq; i_clr_cnt = clr;
        #1;
        en_seen  = o_desc_enable;
        en_model = (m_state == 1 || m_state == 2) && valid;
        @(posedge i_clock);
        model_update(rst, lock, valid, hdr, breq, clr);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b0);
        tests_run++;
        if (o_state !== 2'd0 || o_desc_bypass !== 1'b0 || o_valid !== 1'b0 || o_hdr_err_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_values: state=%0d bypass=%0b valid=%0b err=%0d want 0/0/0/0",
                     o_state, o_desc_bypass, o_valid, o_hdr_err_cnt);
        end
    endtask

    task automatic test_flush_run();
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        tests_run++;
        if (en_seen !== 1'b0 || o_state !== 2'd1) begin
            tests_failed++;
            $display("FAIL lock_to_flush: en=%0b state=%0d want en=0 state=1", en_seen, o_state);
        end
        step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        tests_run++;
        if (en_seen !== 1'b1 || o_state !== 2'd1 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_blk1: en=%0b state=%0d valid=%0b want 1/1/0", en_seen, o_state, o_valid);
        end
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        tests_run++;
        if (en_seen !== 1'b1 || o_state !== 2'd2 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_blk2: en=%0b state=%0d valid=%0b want 1/2/0", en_seen, o_state, o_valid);
        end
        step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        tests_run++;
        if (en_seen !== 1'b1 || o_state !== 2'd2 || o_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL run_first_valid: en=%0b state=%0d valid=%0b want 1/2/1", en_seen, o_state, o_valid);
        end
    endtask

    task automatic test_lock_loss();
        step(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        tests_run++;
        if (o_state !== 2'd0 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_loss: state=%0d valid=%0b want 0/0", o_state, o_valid);
        end
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        tests_run++;
        if (o_state !== 2'd1 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL relock_flush: state=%0d valid=%0b want 1/0", o_state, o_valid);
        end
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        tests_run++;
        if (o_state !== 2'd2 || o_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL relock_run: state=%0d valid=%0b want 2/1", o_state, o_valid);
        end
    endtask

    task automatic test_bypass();
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
        tests_run++;
        if (o_state !== 2'd3 || o_desc_bypass !== 1'b0 || o_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL byp_req: state=%0d bypass=%0b valid=%0b want 3/0/1", o_state, o_desc_bypass, o_valid);
        end
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
        tests_run++;
        if (en_seen !== 1'b0 || o_state !== 2'd2 || o_desc_bypass !== 1'b1 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL byp_reconf: en=%0b state=%0d bypass=%0b valid=%0b want 0/2/1/0",
                     en_seen, o_state, o_desc_bypass, o_valid);
        end
        step(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        tests_run++;
        if (o_state !== 2'd3 || o_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL unbyp_req: state=%0d valid=%0b want 3/1", o_state, o_valid);
        end
        step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        tests_run++;
        if (en_seen !== 1'b0 || o_state !== 2'd1 || o_desc_bypass !== 1'b0) begin
            tests_failed++;
            $display("FAIL unbyp_reconf: en=%0b state=%0d bypass=%0b want 0/1/0", en_seen, o_state, o_desc_bypass);
        end
        step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        tests_run++;
        if (o_state !== 2'd2 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL unbyp_flush: state=%0d valid=%0b want 2/0", o_state, o_valid);
        end
    endtask

    task automatic test_err_count();
        bit [1:0] hdrs [4];
        hdrs[0] = 2'b00; hdrs[1] = 2'b11; hdrs[2] = 2'b01; hdrs[3] = 2'b10;
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b1, hdrs[i], 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        tests_run++;
        if (o_hdr_err_cnt !== 4'd2) begin
            tests_failed++;
            $display("FAIL err_mix: got %0d want 2", o_hdr_err_cnt);
        end
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 1'b1, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 1'b0, 1'b0);
        tests_run++;
        if (o_hdr_err_cnt !== 4'd15) begin
            tests_failed++;
            $display("FAIL err_saturate: got %0d want 15", o_hdr_err_cnt);
        end
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
        tests_run++;
        if (o_hdr_err_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL err_clr_wins: got %0d want 0", o_hdr_err_cnt);
        end
    endtask

    task automatic test_reset_mid_flush();
        step(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
        tests_run++;
        if (o_state !== 2'd0 || o_desc_bypass !== 1'b0 || o_valid !== 1'b0 || o_hdr_err_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_flush: state=%0d bypass=%0b valid=%0b err=%0d want 0/0/0/0",
                     o_state, o_desc_bypass, o_valid, o_hdr_err_cnt);
        end
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        tests_run++;
        if (o_state !== 2'd1) begin
            tests_failed++;
            $display("FAIL flush_restart: state=%0d want 1", o_state);
        end
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        tests_run++;
        if (o_state !== 2'd2) begin
            tests_failed++;
            $display("FAIL flush_restart_run: state=%0d want 2", o_state);
        end
    endtask

    task automatic test_flush_timeout();
        int pulses;
        step(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
            if (flush_to === 1'b1) pulses++;
        end
        tests_run++;
        if (TIMEOUT_EN) begin
            if (o_state !== 2'd0 || flush_to !== 1'b1 || pulses != 1) begin
                tests_failed++;
                $display("FAIL flush_timeout: state=%0d pulse=%0b pulses=%0d want 0/1/1", o_state, flush_to, pulses);
            end
        end else begin
            if (o_state !== 2'd1) begin
                tests_failed++;
                $display("FAIL flush_no_timeout: state=%0d want 1", o_state);
            end
        end
        step(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        tests_run++;
        if (flush_to !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_single_pulse: pulse=%0b want 0", flush_to);
        end
    endtask

    task automatic test_random();
        bit breq;
        breq = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) breq = ~breq;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) != 0,
                 $urandom_range(0, 9) < 7, 2'($urandom), breq,
                 $urandom_range(0, 49) == 0);
            tests_run++;
            if (en_seen !== en_model || o_state !== 2'(m_state) || o_desc_bypass !== m_bypass ||
                o_valid !== m_valid || o_hdr_err_cnt !== 4'(m_err) || flush_to !== m_to) begin
                tests_failed++;
                $display("FAIL random[%0d]: en=%0b/%0b state=%0d/%0d byp=%0b/%0b valid=%0b/%0b err=%0d/%0d to=%0b/%0b (got/want)",
                         i, en_seen, en_model, o_state, m_state, o_desc_bypass, m_bypass,
                         o_valid, m_valid, o_hdr_err_cnt, m_err, flush_to, m_to);
            end
        end
    endtask

    initial begin
        i_reset = 1'b1; i_block_lock = 1'b0; i_valid = 1'b0;
        i_sync_header = 2'b01; i_bypass_req = 1'b0; i_clr_cnt = 1'b0;
        repeat (2) @(posedge i_clock);
        #1;
        test_reset();
        test_flush_run();
        test_lock_loss();
        test_bypass();
        test_err_count();
        test_reset_mid_flush();
        test_flush_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/descrambler_ctrl.md
Name: descrambler_ctrl

Overview:
- Sequences the 58-bit self-synchronizing descrambler in the 100GbE PCS receive path, between block lock/lane deskew and the decoder.
- Gates the descrambler enable, requires a flush period after lock or reconfiguration, and changes bypass only at safe points.
- Produces the output-valid qualifier aligned to the descrambler's one-cycle registered output.
- Counts invalid sync headers seen while in service.

Parameters:
N_FLUSH, 2, valid blocks fed through the descrambler before output is declared valid (one 64-bit payload already exceeds 58 state bits; 2 gives margin); range 1..255
NB_ERR_CNT, 16, width of the saturating sync-header error counter
TIMEOUT_CYCLES, 1024, flush watchdog limit in clock cycles (optional feature only)

Ports:
i_clock  in  1  clock
i_reset  in  1  reset, synchronous, active-high
i_block_lock  in  1  block lock from lock FSM; 0 = lock lost
i_valid  in  1  block on datapath this cycle
i_sync_header  in  2  sync header of current block
i_bypass_req  in  1  requested bypass configuration (level)
i_clr_cnt  in  1  clear error counter (pulse)
o_desc_enable  out  1  drives descrambler i_enable/i_valid (combinational)
o_desc_bypass  out  1  drives descrambler i_bypass (registered)
o_valid  out  1  descrambler output block valid (registered, aligned to descrambler output)
o_state  out  2  current FSM state
o_hdr_err_cnt  out  NB_ERR_CNT  saturating count of sync headers 00/11 in RUN

Behaviour:
- Reset values: state=WAIT_LOCK(0), o_desc_bypass=0, o_valid=0, o_hdr_err_cnt=0, flush counter=0. i_reset forces these mid-operation regardless of other inputs.
- States: WAIT_LOCK=0, FLUSH=1, RUN=2, RECONF=3.
- Lock loss has highest priority: i_block_lock=0 in any state -> WAIT_LOCK next cycle; flush counter cleared.
- WAIT_LOCK:
  - o_desc_enable=0.
  - i_block_lock=1 -> FLUSH with flush count 0, or RUN directly if o_desc_bypass=1.
- FLUSH:
  - o_desc_enable=i_valid; each valid block increments the flush counter.
  - The valid block that brings the count to N_FLUSH -> RUN next cycle.
  - o_valid stays 0 for all flush blocks.
- RUN:
  - o_desc_enable=i_valid; o_valid(t+1)=i_valid(t).
  - If i_bypass_req != o_desc_bypass -> RECONF next cycle. The block present in that cycle is still processed with the old bypass value.
- RECONF:
  - Lasts exactly 1 cycle with o_desc_enable=0; a block arriving that cycle is dropped (o_valid=0 next cycle).
  - o_desc_bypass <= i_bypass_req sampled in RECONF.
  - Next state: RUN if the new bypass=1, else FLUSH with counter cleared.
- i_bypass_req changes outside RUN are not acted on until RUN. Exception: in WAIT_LOCK, o_desc_bypass tracks i_bypass_req directly.
- o_valid is 0 in the cycle after any non-RUN state, except when leaving RUN, where it reflects the last RUN-cycle block.
- Error counter:
  - Increments on i_valid && state==RUN && (i_sync_header==2'b00 || 2'b11).
  - Saturates at all-ones, with no wrap.
  - i_clr_cnt wins over a simultaneous increment (result 0).
- o_state is the registered state.

Optional Feature:
- Macro DESC_CTRL_FLUSH_TIMEOUT_EN.
- When defined:
  - A watchdog counter (clog2(TIMEOUT_CYCLES) bits) runs in FLUSH; it clears on each valid block and on entry.
  - Reaching TIMEOUT_CYCLES consecutive cycles without i_valid forces WAIT_LOCK.
  - Adds output o_flush_timeout (1 bit, reset 0), a one-cycle pulse on that transition.
- When undefined: no watchdog and no o_flush_timeout port; FLUSH waits indefinitely.

Test Plan:
- Reset release, i_block_lock=1, i_valid=1 every cycle, N_FLUSH=2 -> o_state 0->1 (cycle 1), 1->2 after 2nd valid block; o_valid first 1 one cycle after first RUN valid block; o_desc_enable=1 throughout FLUSH/RUN.
- In RUN, drop i_block_lock for 1 cycle -> WAIT_LOCK next cycle, o_valid=0; relock -> full 2-block flush before o_valid returns.
- In RUN, i_bypass_req 0->1 -> one RECONF cycle with o_desc_enable=0, o_desc_bypass=1, back to RUN with no flush. Then 1->0 -> RECONF, then FLUSH of 2 blocks.
- In RUN, inject headers 00, 11, 01, 10 on valid blocks -> o_hdr_err_cnt=2. Preload near saturation with NB_ERR_CNT=4 and inject 20 errors -> stays 15. Assert i_clr_cnt with an error in the same cycle -> 0.
- Assert i_reset during FLUSH with count 1 -> all outputs at reset values next cycle; counter restarts at 0 after relock.
- With DESC_CTRL_FLUSH_TIMEOUT_EN, TIMEOUT_CYCLES=16: enter FLUSH, hold i_valid=0 for 16 cycles -> o_flush_timeout pulses once, o_state=0. Without the macro, same stimulus -> remains in FLUSH.
